// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone slave mux controller.
// Holds the FSM state type, slave indices, error encoding and the address decoder.
package wb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic SLV_UART = 1'b0;
  localparam logic SLV_USER = 1'b1;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_BUS  = 1'b1;

  typedef struct packed {
    logic hit;
    logic idx;
  } decode_t;

  // Map the upper address half onto a slave index; hit=0 means unmapped.
  function automatic decode_t decode_slave(input logic [15:0] page,
                                           input logic [15:0] s0_base,
                                           input logic [15:0] s1_base);
    decode_t res;
    res.hit = 1'b1;
    res.idx = SLV_UART;
    if (page == s0_base) begin
      res.idx = SLV_UART;
    end else if (page == s1_base) begin
      res.idx = SLV_USER;
    end else begin
      res.hit = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Cycle watchdog: counts enabled cycles after a clear and pulses expire
// on the cycle where the count has reached TIMEOUT-1.
module wb_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count_r;

  // Count enabled cycles, parking at LAST until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && !clr && (count_r == LAST);

endmodule

// File: rtl/wb_slave_mux_ctrl.sv
// Registered Wishbone controller forwarding one transaction at a time to the
// UART or user-project slave, with error termination of unmapped/stalled accesses.
module wb_slave_mux_ctrl
  import wb_mux_pkg::*;
#(
  parameter logic [15:0] S0_BASE  = 16'h3000,
  parameter logic [15:0] S1_BASE  = 16'h3800,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_err_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  input  logic        s0_ack_i,
  input  logic [31:0] s0_dat_i,
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  input  logic        s1_ack_i,
  input  logic [31:0] s1_dat_i,
  output logic [7:0]  timeout_cnt_o
);

  state_e      state_r;
  logic        sel_idx_r;
  logic        req_s;
  decode_t     dec_s;
  logic        sel_ack_s;
  logic [31:0] sel_dat_s;
  logic        wd_clr_s;
  logic        wd_en_s;
  logic        wd_expire_s;

  // Request detect, address decode and steering of the selected slave's response.
  always_comb begin
    req_s    = wbs_cyc_i & wbs_stb_i;
    dec_s    = decode_slave(wbs_adr_i[31:16], S0_BASE, S1_BASE);
    wd_en_s  = (state_r == ACTIVE);
    wd_clr_s = (state_r != ACTIVE);
    if (sel_idx_r == SLV_USER) begin
      sel_ack_s = s1_ack_i;
      sel_dat_s = s1_dat_i;
    end else begin
      sel_ack_s = s0_ack_i;
      sel_dat_s = s0_dat_i;
    end
  end

  wb_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (wd_clr_s),
    .en    (wd_en_s),
    .expire(wd_expire_s)
  );

  // Transaction FSM; every bus-facing output is a register updated here.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r       <= IDLE;
      sel_idx_r     <= SLV_UART;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= 32'h0000_0000;
      wbs_err_o     <= ERR_NONE;
      s_we_o        <= 1'b0;
      s_sel_o       <= 4'h0;
      s_adr_o       <= 32'h0000_0000;
      s_dat_o       <= 32'h0000_0000;
      s0_cyc_o      <= 1'b0;
      s0_stb_o      <= 1'b0;
      s1_cyc_o      <= 1'b0;
      s1_stb_o      <= 1'b0;
      timeout_cnt_o <= 8'h00;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            s_we_o    <= wbs_we_i;
            s_sel_o   <= wbs_sel_i;
            s_adr_o   <= wbs_adr_i;
            s_dat_o   <= wbs_dat_i;
            sel_idx_r <= dec_s.idx;
            if (dec_s.hit) begin
              state_r  <= ACTIVE;
              s0_cyc_o <= (dec_s.idx == SLV_UART);
              s0_stb_o <= (dec_s.idx == SLV_UART);
              s1_cyc_o <= (dec_s.idx == SLV_USER);
              s1_stb_o <= (dec_s.idx == SLV_USER);
            end else begin
              state_r   <= RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= ERR_DATA;
              wbs_err_o <= ERR_BUS;
            end
          end
        end
        ACTIVE: begin
          // Abort beats ack, ack beats timeout.
          if (!wbs_cyc_i) begin
            state_r  <= IDLE;
            s0_cyc_o <= 1'b0;
            s0_stb_o <= 1'b0;
            s1_cyc_o <= 1'b0;
            s1_stb_o <= 1'b0;
          end else if (sel_ack_s) begin
            state_r   <= RESP;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= sel_dat_s;
            wbs_err_o <= ERR_NONE;
            s0_cyc_o  <= 1'b0;
            s0_stb_o  <= 1'b0;
            s1_cyc_o  <= 1'b0;
            s1_stb_o  <= 1'b0;
          end else if (wd_expire_s) begin
            state_r   <= RESP;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= ERR_DATA;
            wbs_err_o <= ERR_BUS;
            s0_cyc_o  <= 1'b0;
            s0_stb_o  <= 1'b0;
            s1_cyc_o  <= 1'b0;
            s1_stb_o  <= 1'b0;
            if (timeout_cnt_o != 8'hFF) begin
              timeout_cnt_o <= timeout_cnt_o + 8'd1;
            end
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          s0_cyc_o <= 1'b0;
          s0_stb_o <= 1'b0;
          s1_cyc_o <= 1'b0;
          s1_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mux_ctrl.sv
// Directed plus randomized bench for wb_slave_mux_ctrl with an outcome-level
// reference model (which slave, how many strobe cycles, when and what the ack is).
module tb_wb_slave_mux_ctrl;

  localparam int          TMO  = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
  logic [3:0]  wbs_sel = 4'h0;
  logic [31:0] wbs_adr = 32'h0, wbs_dat = 32'h0;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o;
  logic        s0_ack = 1'b0, s1_ack = 1'b0;
  logic [31:0] s0_dat = 32'h0, s1_dat = 32'h0;
  logic [7:0]  timeout_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;
  int tmo_model = 0;

  always #5 clk = ~clk;

  wb_slave_mux_ctrl #(
    .S0_BASE(16'h3000), .S1_BASE(16'h3800), .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
    .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .wbs_err_o(wbs_err_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_ack_i(s0_ack), .s0_dat_i(s0_dat),
    .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_ack_i(s1_ack), .s1_dat_i(s1_dat),
    .timeout_cnt_o(timeout_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One master transaction; d = slave ack delay in cycles after its strobe is seen.
  task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input int d, input logic [31:0] rdat);
    int tgt, exp_ack_n, exp_stb0, exp_stb1, ack_n, stb0_n, stb1_n, cyc_bad;
    logic [31:0] exp_dat, got_dat;
    logic exp_err, got_err;
    if (adr[31:16] == 16'h3000) tgt = 0;
    else if (adr[31:16] == 16'h3800) tgt = 1;
    else tgt = -1;
    exp_stb0 = 0;
    exp_stb1 = 0;
    if (tgt < 0) begin
      exp_ack_n = 1; exp_dat = ERRD; exp_err = 1'b1;
    end else if (d < TMO) begin
      exp_ack_n = d + 2; exp_dat = rdat; exp_err = 1'b0;
      if (tgt == 0) exp_stb0 = d + 1; else exp_stb1 = d + 1;
    end else begin
      exp_ack_n = TMO + 1; exp_dat = ERRD; exp_err = 1'b1;
      if (tgt == 0) exp_stb0 = TMO; else exp_stb1 = TMO;
      tmo_model = (tmo_model < 255) ? tmo_model + 1 : 255;
    end
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_sel = sel;
    wbs_adr = adr; wbs_dat = wdat;
    ack_n = 0; stb0_n = 0; stb1_n = 0; cyc_bad = 0;
    got_dat = 32'h0; got_err = 1'b0;
    for (int n = 1; n <= TMO + 20; n++) begin
      @(negedge clk);
      s0_ack = 1'b0; s1_ack = 1'b0; s0_dat = $urandom; s1_dat = $urandom;
      if (s0_stb_o) stb0_n++;
      if (s1_stb_o) stb1_n++;
      if (s0_cyc_o !== s0_stb_o || s1_cyc_o !== s1_stb_o) cyc_bad++;
      if (wbs_ack_o) begin
        ack_n = n; got_dat = wbs_dat_o; got_err = wbs_err_o;
        break;
      end
      if (tgt == 0 && n == d + 1) begin s0_ack = 1'b1; s0_dat = rdat; end
      if (tgt == 1 && n == d + 1) begin s1_ack = 1'b1; s1_dat = rdat; end
      if (tgt != 0) s0_ack = 1'($urandom_range(0, 1));
      if (tgt != 1) s1_ack = 1'($urandom_range(0, 1));
    end
    wbs_cyc = 1'b0; wbs_stb = 1'b0; s0_ack = 1'b0; s1_ack = 1'b0;
    check({tag, "/ack_cycle"}, ack_n, exp_ack_n);
    check({tag, "/rdata"}, got_dat, exp_dat);
    check({tag, "/err"}, 32'(got_err), 32'(exp_err));
    check({tag, "/s0_stb_cycles"}, stb0_n, exp_stb0);
    check({tag, "/s1_stb_cycles"}, stb1_n, exp_stb1);
    check({tag, "/cyc_eq_stb"}, cyc_bad, 0);
    check({tag, "/s_adr"}, s_adr_o, adr);
    check({tag, "/s_dat"}, s_dat_o, wdat);
    check({tag, "/s_we_sel"}, {27'd0, s_we_o, s_sel_o}, {27'd0, we, sel});
    check({tag, "/timeout_cnt"}, 32'(timeout_cnt_o), tmo_model);
    @(negedge clk);
    check({tag, "/ack_single"}, 32'(wbs_ack_o), 0);
    check({tag, "/dat_hold"}, wbs_dat_o, exp_dat);
  endtask

  initial begin
    logic [31:0] adr, held;
    int r;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset/ack", 32'(wbs_ack_o), 0);
    check("reset/err", 32'(wbs_err_o), 0);
    check("reset/dat", wbs_dat_o, 0);
    check("reset/stb", {30'd0, s0_stb_o | s0_cyc_o, s1_stb_o | s1_cyc_o}, 0);
    check("reset/latches", s_adr_o | s_dat_o | {27'd0, s_we_o, s_sel_o}, 0);
    check("reset/timeout_cnt", 32'(timeout_cnt_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("s0_read", 32'h3000_0004, 1'b0, 32'h0, 4'hF, 2, 32'h0000_00A5);
    run_txn("s1_write", 32'h3800_0010, 1'b1, 32'h1234_5678, 4'hF, 3, 32'h0BAD_F00D);
    run_txn("unmapped", 32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
    run_txn("s1_timeout", 32'h3800_0020, 1'b0, 32'h0, 4'h3, NEVER, 32'h0);
    run_txn("ack_tie", 32'h3000_0008, 1'b0, 32'h0, 4'hF, TMO - 1, 32'hCAFE_0001);
    run_txn("ack_zero", 32'h3800_0000, 1'b1, 32'h0000_0055, 4'h1, 0, 32'h7777_0000);

    // Abort three cycles into ACTIVE with a coincident slave ack.
    held = wbs_dat_o;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h3000_0100;
    for (int n = 1; n <= 3; n++) @(negedge clk);
    check("abort/stb_before", 32'(s0_stb_o), 1);
    wbs_cyc = 1'b0; wbs_stb = 1'b0; s0_ack = 1'b1; s0_dat = 32'h5555_AAAA;
    @(negedge clk);
    s0_ack = 1'b0;
    check("abort/no_ack", 32'(wbs_ack_o), 0);
    check("abort/stb_low", {30'd0, s0_stb_o, s1_stb_o}, 0);
    @(negedge clk);
    check("abort/no_ack_late", 32'(wbs_ack_o), 0);
    check("abort/dat_held", wbs_dat_o, held);
    check("abort/timeout_cnt", 32'(timeout_cnt_o), tmo_model);
    run_txn("after_abort", 32'h3000_0200, 1'b0, 32'h0, 4'hF, 1, 32'h0000_1234);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) adr = {16'h3000, 16'($urandom)};
      else if (r == 1) adr = {16'h3800, 16'($urandom)};
      else begin
        adr = $urandom;
        while (adr[31:16] == 16'h3000 || adr[31:16] == 16'h3800) adr = $urandom;
      end
      run_txn("random", adr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
              $urandom_range(0, TMO + 4), $urandom);
    end

    for (int i = 0; i < 300; i++)
      run_txn("tmo_sat", {16'h3800, 16'($urandom)}, 1'b0, 32'h0, 4'hF, NEVER, 32'h0);
    check("tmo_sat/final", 32'(timeout_cnt_o), 255);

    // Asynchronous reset in the middle of an ACTIVE access.
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_adr = 32'h3800_0040;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    check("rst_mid/stb_before", 32'(s1_stb_o), 1);
    #2 rst_n = 1'b0; s1_ack = 1'b1;
    #1;
    check("rst_mid/stb", {28'd0, s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o}, 0);
    check("rst_mid/ack", 32'(wbs_ack_o), 0);
    check("rst_mid/timeout_cnt", 32'(timeout_cnt_o), 0);
    tmo_model = 0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; s1_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn("after_rst", 32'h3800_0044, 1'b1, 32'hA5A5_5A5A, 4'hC, 4, 32'h0F0F_0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
